// File: rtl/router_pkg.sv
// Shared definitions for the output tile sequencer and the downstream row router controller.
package router_pkg;

  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_ROUTER_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/stride_axis_counter.sv
// One axis of the output-map walk: input-space origin plus output-space index,
// with a lookahead flag telling whether one more step keeps the kernel inside the map.
module stride_axis_counter #(
  parameter int ORG_W  = 9,
  parameter int STEP_W = 8,
  parameter int IDX_W  = 8,
  parameter int SIZE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic [STEP_W-1:0] step_amt,
  input  logic [IDX_W-1:0]  idx_step,
  input  logic [SIZE_W-1:0] k_size,
  input  logic [SIZE_W-1:0] i_size,
  output logic [IDX_W-1:0]  idx,
  output logic              in_range
);

  localparam int WIDE_W = (ORG_W > STEP_W) ? ORG_W : STEP_W;
  localparam int SUM_W  = ((WIDE_W > SIZE_W) ? WIDE_W : SIZE_W) + 2;

  logic [ORG_W-1:0] origin_r;
  logic [IDX_W-1:0] idx_r;
  logic [SUM_W-1:0] reach_s;

  // Far edge of the kernel window after one more step; sized so it cannot wrap.
  always_comb begin
    reach_s  = SUM_W'(origin_r) + SUM_W'(step_amt) + SUM_W'(k_size);
    in_range = (reach_s <= SUM_W'(i_size));
  end

  // Origin and index advance together; a step only happens when in range, so the origin fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      origin_r <= {ORG_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
    end else if (clr) begin
      origin_r <= {ORG_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
    end else if (step) begin
      origin_r <= origin_r + ORG_W'(step_amt);
      idx_r    <= idx_r + idx_step;
    end
  end

  assign idx = idx_r;

endmodule

// File: rtl/output_tile_sequencer.sv
// Walks one layer's output map and hands (o_x, o_y) tiles to the row router controller,
// one at a time, with a register clear between tiles and a done pulse at the end.
module output_tile_sequencer
  import router_pkg::*;
#(
  parameter int ROUTER_COUNT = DEF_ROUTER_COUNT,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reg_clear,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [ADDR_WIDTH-1:0] i_k_size,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic                  i_rrc_done,
  output logic [ADDR_WIDTH-1:0] o_o_x,
  output logic [ADDR_WIDTH-1:0] o_o_y,
  output logic [ADDR_WIDTH-1:0] o_i_size,
  output logic                  o_rrc_en,
  output logic                  o_rrc_clear,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int ORG_W  = ADDR_WIDTH + 1;
  localparam int INCR_W = ADDR_WIDTH + $clog2(ROUTER_COUNT + 1);

  seq_state_e            state_r;
  logic [ADDR_WIDTH-1:0] i_size_r;
  logic [ADDR_WIDTH-1:0] k_size_r;
  logic [ADDR_WIDTH-1:0] stride_r;
  logic [INCR_W-1:0]     incr_r;
  logic                  en_r;
  logic                  clear_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;

  logic                  legal_s;
  logic                  x_clr_s;
  logic                  x_step_s;
  logic                  y_clr_s;
  logic                  y_step_s;
  logic                  x_in_range_s;
  logic                  y_in_range_s;
  logic [ADDR_WIDTH-1:0] x_idx_s;
  logic [ADDR_WIDTH-1:0] y_idx_s;

  // Configuration check on the live inputs, evaluated when a start arrives in IDLE.
  always_comb begin
    legal_s = (i_k_size != {ADDR_WIDTH{1'b0}}) &&
              (i_stride != {ADDR_WIDTH{1'b0}}) &&
              (i_k_size <= i_i_size);
  end

  // Axis control: the x axis restarts whenever the walk drops to the next row of tiles.
  always_comb begin
    x_clr_s  = 1'b0;
    x_step_s = 1'b0;
    y_clr_s  = 1'b0;
    y_step_s = 1'b0;
    if (i_reg_clear) begin
      x_clr_s = 1'b1;
      y_clr_s = 1'b1;
    end else if ((state_r == IDLE) && i_start && legal_s) begin
      x_clr_s = 1'b1;
      y_clr_s = 1'b1;
    end else if (state_r == CLEAR) begin
      if (x_in_range_s) begin
        x_step_s = 1'b1;
      end else if (y_in_range_s) begin
        x_clr_s  = 1'b1;
        y_step_s = 1'b1;
      end else begin
        x_step_s = 1'b0;
      end
    end else begin
      x_step_s = 1'b0;
    end
  end

  stride_axis_counter #(
    .ORG_W (ORG_W),
    .STEP_W(ADDR_WIDTH),
    .IDX_W (ADDR_WIDTH),
    .SIZE_W(ADDR_WIDTH)
  ) u_x_axis (
    .clk     (i_clk),
    .rst_n   (i_nrst),
    .clr     (x_clr_s),
    .step    (x_step_s),
    .step_amt(stride_r),
    .idx_step(ADDR_WIDTH'(1)),
    .k_size  (k_size_r),
    .i_size  (i_size_r),
    .idx     (x_idx_s),
    .in_range(x_in_range_s)
  );

  stride_axis_counter #(
    .ORG_W (ORG_W),
    .STEP_W(INCR_W),
    .IDX_W (ADDR_WIDTH),
    .SIZE_W(ADDR_WIDTH)
  ) u_y_axis (
    .clk     (i_clk),
    .rst_n   (i_nrst),
    .clr     (y_clr_s),
    .step    (y_step_s),
    .step_amt(incr_r),
    .idx_step(ADDR_WIDTH'(ROUTER_COUNT)),
    .k_size  (k_size_r),
    .i_size  (i_size_r),
    .idx     (y_idx_s),
    .in_range(y_in_range_s)
  );

  // Sequencer FSM; every handshake output is registered alongside the state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_r  <= IDLE;
      i_size_r <= {ADDR_WIDTH{1'b0}};
      k_size_r <= {ADDR_WIDTH{1'b0}};
      stride_r <= {ADDR_WIDTH{1'b0}};
      incr_r   <= {INCR_W{1'b0}};
      en_r     <= 1'b0;
      clear_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else if (i_reg_clear) begin
      state_r  <= IDLE;
      i_size_r <= {ADDR_WIDTH{1'b0}};
      k_size_r <= {ADDR_WIDTH{1'b0}};
      stride_r <= {ADDR_WIDTH{1'b0}};
      incr_r   <= {INCR_W{1'b0}};
      en_r     <= 1'b0;
      clear_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start) begin
            if (legal_s) begin
              i_size_r <= i_i_size;
              k_size_r <= i_k_size;
              stride_r <= i_stride;
              incr_r   <= INCR_W'(i_stride) * INCR_W'(ROUTER_COUNT);
              state_r  <= ISSUE;
              en_r     <= 1'b1;
              busy_r   <= 1'b1;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (i_rrc_done) begin
            state_r <= CLEAR;
            en_r    <= 1'b0;
            clear_r <= 1'b1;
          end
        end
        CLEAR: begin
          clear_r <= 1'b0;
          if (x_in_range_s || y_in_range_s) begin
            state_r <= ISSUE;
            en_r    <= 1'b1;
          end else begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          en_r    <= 1'b0;
          clear_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_o_x       = x_idx_s;
  assign o_o_y       = y_idx_s;
  assign o_i_size    = i_size_r;
  assign o_rrc_en    = en_r;
  assign o_rrc_clear = clear_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_err       = err_r;

endmodule

// File: tb/tb_output_tile_sequencer.sv
// Bench for output_tile_sequencer: two instances (4 and 2 router banks) share the inputs,
// each served by its own controller model; issued tiles are checked against a list built from the walk rules.
module tb_output_tile_sequencer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       reg_clear;
  logic       start;
  logic [7:0] i_size;
  logic [7:0] k_size;
  logic [7:0] stride;
  logic       rrc_done [2];
  logic [7:0] ox [2];
  logic [7:0] oy [2];
  logic [7:0] isz [2];
  logic       en [2];
  logic       clr [2];
  logic       busy [2];
  logic       done [2];
  logic       err [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  output_tile_sequencer #(.ROUTER_COUNT(4), .ADDR_WIDTH(8)) dut4 (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear), .i_start(start),
    .i_i_size(i_size), .i_k_size(k_size), .i_stride(stride), .i_rrc_done(rrc_done[0]),
    .o_o_x(ox[0]), .o_o_y(oy[0]), .o_i_size(isz[0]), .o_rrc_en(en[0]),
    .o_rrc_clear(clr[0]), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
  );

  output_tile_sequencer #(.ROUTER_COUNT(2), .ADDR_WIDTH(8)) dut2 (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(reg_clear), .i_start(start),
    .i_i_size(i_size), .i_k_size(k_size), .i_stride(stride), .i_rrc_done(rrc_done[1]),
    .o_o_x(ox[1]), .o_o_y(oy[1]), .o_i_size(isz[1]), .o_rrc_en(en[1]),
    .o_rrc_clear(clr[1]), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
  );

  // Controller model: answers ctl_delay cycles into each enable, optionally holding done one cycle too long.
  int ctl_delay   = 3;
  bit ctl_spurious = 1'b0;
  int ctl_cnt [2] = '{0, 0};
  bit ctl_extra [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en[d] === 1'b1) begin
        ctl_cnt[d]++;
        rrc_done[d] = (ctl_cnt[d] >= ctl_delay);
        ctl_extra[d] = ctl_spurious;
      end else if (rrc_done[d] && ctl_extra[d]) begin
        ctl_extra[d] = 1'b0;
        ctl_cnt[d] = 0;
      end else begin
        ctl_cnt[d] = 0;
        rrc_done[d] = 1'b0;
      end
    end
  end

  // Monitor: records each issued tile and counts handshake pulses.
  int  got_q [2][$];
  int  exp_q [2][$];
  int  clr_cnt [2];
  int  done_cnt [2];
  int  err_cnt [2];
  int  busy_cnt [2];
  int  busy_gap [2];
  int  unstable [2];
  int  en_cycles [2];
  bit  active [2];
  logic prev_en [2];
  int  cur_x [2];
  int  cur_y [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en[d] === 1'b1 && prev_en[d] !== 1'b1) begin
        got_q[d].push_back(int'(ox[d]) * 1024 + int'(oy[d]));
        cur_x[d] = int'(ox[d]);
        cur_y[d] = int'(oy[d]);
        active[d] = 1'b1;
      end else if (en[d] === 1'b1 && (int'(ox[d]) != cur_x[d] || int'(oy[d]) != cur_y[d])) begin
        unstable[d]++;
      end
      if (en[d] === 1'b1) en_cycles[d]++;
      if (clr[d] === 1'b1) clr_cnt[d]++;
      if (busy[d] === 1'b1) busy_cnt[d]++;
      if (err[d] === 1'b1) err_cnt[d]++;
      if (done[d] === 1'b1) begin
        done_cnt[d]++;
        active[d] = 1'b0;
      end else if (active[d] && busy[d] !== 1'b1) begin
        busy_gap[d]++;
      end
      prev_en[d] = en[d];
    end
  end

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      got_q[d].delete();
      clr_cnt[d] = 0; done_cnt[d] = 0; err_cnt[d] = 0; busy_cnt[d] = 0;
      busy_gap[d] = 0; unstable[d] = 0; en_cycles[d] = 0;
      active[d] = 1'b0; prev_en[d] = en[d];
    end
  endtask

  // Reference walk: kernel origins step by stride in x and by stride*banks in y while the kernel fits.
  task automatic gen_expected(input int i, input int k, input int s);
    int rc, iy, ix, tx, ty;
    for (int d = 0; d < 2; d++) begin
      rc = (d == 0) ? 4 : 2;
      exp_q[d].delete();
      iy = 0; ty = 0;
      while (iy + k <= i) begin
        ix = 0; tx = 0;
        while (ix + k <= i) begin
          exp_q[d].push_back(tx * 1024 + ty * rc);
          ix += s; tx++;
        end
        iy += s * rc; ty++;
      end
    end
  endtask

  function automatic bit all_zero(input int d);
    return (ox[d] === 8'd0) && (oy[d] === 8'd0) && (isz[d] === 8'd0) && (en[d] === 1'b0) &&
           (clr[d] === 1'b0) && (busy[d] === 1'b0) && (done[d] === 1'b0) && (err[d] === 1'b0);
  endfunction

  task automatic run_layer(input int i, input int k, input int s, input int dly, input bit spur,
                           input string name);
    int bound;
    int last;
    bit ok;
    gen_expected(i, k, s);
    ctl_delay = dly;
    ctl_spurious = spur;
    @(negedge clk); #1;
    clear_mon();
    i_size = 8'(i); k_size = 8'(k); stride = 8'(s); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    i_size = 8'($urandom); k_size = 8'($urandom); stride = 8'($urandom);
    bound = exp_q[1].size() * (dly + 4) + 50;
    for (int c = 0; c < bound && !(done_cnt[0] > 0 && done_cnt[1] > 0); c++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (done_cnt[d] != 1) begin
        bad++; $display("FAIL %s dut%0d done_pulses: got %0d expected 1", name, d, done_cnt[d]);
      end
      ok = (got_q[d].size() == exp_q[d].size());
      for (int n = 0; ok && n < exp_q[d].size(); n++) ok = (got_q[d][n] == exp_q[d][n]);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL %s dut%0d items: got %0d items (first x=%0d y=%0d) expected %0d items", name, d,
                 got_q[d].size(), (got_q[d].size() > 0) ? got_q[d][0] / 1024 : -1,
                 (got_q[d].size() > 0) ? got_q[d][0] % 1024 : -1, exp_q[d].size());
      end
      total++;
      if (clr_cnt[d] != exp_q[d].size()) begin
        bad++; $display("FAIL %s dut%0d clear_pulses: got %0d expected %0d", name, d, clr_cnt[d], exp_q[d].size());
      end
      total++;
      if (en_cycles[d] != exp_q[d].size() * dly) begin
        bad++; $display("FAIL %s dut%0d enable_cycles: got %0d expected %0d", name, d, en_cycles[d], exp_q[d].size() * dly);
      end
      total++;
      if (busy_gap[d] != 0 || unstable[d] != 0 || err_cnt[d] != 0) begin
        bad++; $display("FAIL %s dut%0d busy_gap/unstable/err: got %0d/%0d/%0d expected 0/0/0", name, d,
                        busy_gap[d], unstable[d], err_cnt[d]);
      end
      last = exp_q[d][exp_q[d].size() - 1];
      total++;
      if (int'(isz[d]) != i || int'(ox[d]) != last / 1024 || int'(oy[d]) != last % 1024 || busy[d] !== 1'b0) begin
        bad++; $display("FAIL %s dut%0d held_outputs: got isz=%0d x=%0d y=%0d busy=%b expected isz=%0d x=%0d y=%0d busy=0",
                        name, d, isz[d], ox[d], oy[d], busy[d], i, last / 1024, last % 1024);
      end
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; reg_clear = 1'b0; start = 1'b0;
    i_size = 8'd0; k_size = 8'd0; stride = 8'd0;
    rrc_done[0] = 1'b0; rrc_done[1] = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (!all_zero(d)) begin
        bad++; $display("FAIL reset dut%0d outputs: got en=%b busy=%b x=%0d y=%0d expected all zero", d, en[d], busy[d], ox[d], oy[d]);
      end
    end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_illegal(input int i, input int k, input int s, input string name);
    @(negedge clk); #1;
    clear_mon();
    i_size = 8'(i); k_size = 8'(k); stride = 8'(s); start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (err[d] !== 1'b1) begin
        bad++; $display("FAIL %s dut%0d err_next_cycle: got %b expected 1", name, d, err[d]);
      end
    end
    repeat (6) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (err_cnt[d] != 1 || busy_cnt[d] != 0 || got_q[d].size() != 0 || done_cnt[d] != 0) begin
        bad++; $display("FAIL %s dut%0d err_only: got err_cycles=%0d busy_cycles=%0d items=%0d done=%0d expected 1/0/0/0",
                        name, d, err_cnt[d], busy_cnt[d], got_q[d].size(), done_cnt[d]);
      end
    end
  endtask

  task automatic test_abort(input bit use_nrst, input string name);
    ctl_delay = 3; ctl_spurious = 1'b0;
    @(negedge clk); #1;
    clear_mon();
    i_size = 8'd8; k_size = 8'd3; stride = 8'd1; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 40 && got_q[0].size() < 2; c++) begin
      @(negedge clk); #1;
    end
    total++;
    if (got_q[0].size() != 2) begin
      bad++; $display("FAIL %s reach_item2: got %0d items expected 2", name, got_q[0].size());
    end
    if (use_nrst) begin
      nrst = 1'b0;
      #1;
    end else begin
      reg_clear = 1'b1; start = 1'b1;
      @(negedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (!all_zero(d)) begin
        bad++; $display("FAIL %s dut%0d outputs_zero: got en=%b clr=%b busy=%b x=%0d y=%0d isz=%0d expected all zero",
                        name, d, en[d], clr[d], busy[d], ox[d], oy[d], isz[d]);
      end
    end
    reg_clear = 1'b0; start = 1'b0;
    @(negedge clk); #1;
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (done_cnt[d] != 0 || en[d] !== 1'b0 || got_q[d].size() != 2) begin
        bad++; $display("FAIL %s dut%0d no_done_after_abort: got done=%0d en=%b items=%0d expected 0/0/2",
                        name, d, done_cnt[d], en[d], got_q[d].size());
      end
    end
    run_layer(8, 3, 1, 2, 1'b0, {name, "_replay"});
  endtask

  task automatic test_random();
    int i, k, s, dly;
    for (int n = 0; n < 8; n++) begin
      i = $urandom_range(1, 16);
      k = $urandom_range(1, i);
      s = $urandom_range(1, 4);
      dly = $urandom_range(1, 4);
      run_layer(i, k, s, dly, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    run_layer(5, 3, 1, 3, 1'b0, "row_only");
    run_layer(8, 3, 1, 3, 1'b0, "multi_tile");
    run_layer(7, 3, 2, 3, 1'b0, "stride2");
    run_layer(5, 5, 1, 2, 1'b0, "k_eq_i");
    test_illegal(5, 6, 1, "k_gt_i");
    test_illegal(5, 3, 0, "stride0");
    test_illegal(5, 0, 1, "k0");
    run_layer(4, 3, 1, 12, 1'b0, "stall");
    run_layer(6, 3, 1, 3, 1'b1, "spurious_done");
    test_abort(1'b0, "abort_clear");
    test_abort(1'b1, "abort_nrst");
    run_layer(9, 2, 3, 1, 1'b0, "back_to_back_a");
    run_layer(9, 2, 3, 1, 1'b1, "back_to_back_b");
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_tile_sequencer.md
Name: output_tile_sequencer

Overview:
- Upstream stage of row_router_controller.
- Walks the output feature map of one convolution layer and issues one (o_x, o_y) work item at a time to the controller.
- o_x steps by one output column; o_y steps by ROUTER_COUNT output rows, one tile per router bank.
- Handshakes on the controller's o_rr_en and pulses its i_reg_clear between items, then signals layer completion.

Parameters:
- ROUTER_COUNT, 4, output rows covered per issued item; must match the downstream controller.
- ADDR_WIDTH, 8, width of sizes and coordinates.

Ports:
- i_clk  input  1  clock.
- i_nrst  input  1  asynchronous active-low reset.
- i_reg_clear  input  1  synchronous clear; aborts any sequence.
- i_start  input  1  one-cycle start pulse; sampled only in IDLE.
- i_i_size  input  ADDR_WIDTH  square input map size.
- i_k_size  input  ADDR_WIDTH  square kernel size.
- i_stride  input  ADDR_WIDTH  convolution stride.
- i_rrc_done  input  1  controller done (its o_rr_en).
- o_o_x  output  ADDR_WIDTH  output column index to controller i_o_x.
- o_o_y  output  ADDR_WIDTH  first output row of tile to controller i_o_y.
- o_i_size  output  ADDR_WIDTH  latched input size to controller i_i_size.
- o_rrc_en  output  1  controller enable (i_en).
- o_rrc_clear  output  1  controller register clear (i_reg_clear).
- o_busy  output  1  high from ISSUE through CLEAR.
- o_done  output  1  one-cycle pulse when the layer completes.
- o_err  output  1  one-cycle pulse on illegal configuration.

Behaviour:
- Reset (i_nrst low, asynchronous): all outputs 0; state IDLE; internal counters 0.
- i_reg_clear high at a clock edge: same values as reset, synchronously. It overrides every other input, including a simultaneous i_start or i_rrc_done.
- The same abort applies mid-sequence; no o_done is emitted.
- Configuration (i_size, k_size, stride) is latched on an accepted i_start. Input changes afterwards have no effect until the next start.
- Illegal configuration is k_size==0, stride==0 or k_size>i_size. i_start in IDLE with illegal config gives o_err=1 for the next cycle only; state stays IDLE; o_busy stays 0.
- Internal origin counters: ix and iy, ADDR_WIDTH+1 bits.
  - iy increment = stride*ROUTER_COUNT, computed once at start into a register wide enough to avoid overflow.
  - All comparisons are unsigned.
- FSM states:
  - IDLE: on legal i_start, latch config, set ix=iy=o_o_x=o_o_y=0, go to ISSUE.
  - ISSUE: o_rrc_en=1 and o_busy=1. o_o_x, o_o_y and o_i_size are held stable. Wait here indefinitely while i_rrc_done=0. When i_rrc_done=1, go to CLEAR.
  - CLEAR: o_rrc_en=0 and o_rrc_clear=1 for exactly one cycle. Advance:
    - if ix+stride+k_size <= i_size: ix+=stride, o_o_x+=1, go to ISSUE;
    - else if iy+incr+k_size <= i_size: ix=0, o_o_x=0, iy+=incr, o_o_y+=ROUTER_COUNT, go to ISSUE;
    - else go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE. Coordinates hold their last values until the next start.
- Timing:
  - i_start sampled at edge t puts o_rrc_en high after t, with coordinates 0,0.
  - i_rrc_done sampled at edge c: o_rrc_en falls and o_rrc_clear rises after c.
  - Next item is presented after c+1 (o_rrc_en high again), or o_done after c+1.
- i_rrc_done is ignored outside ISSUE. i_start is ignored outside IDLE.
- Tiles whose later rows fall past the map edge are still issued once their first row is legal; masking those rows is the controller's responsibility.
- k_size==i_size gives exactly one item (0,0).

Decomposition:
- Shared package router_pkg holds:
  - the FSM state enum typedef (IDLE, ISSUE, CLEAR, DONE);
  - default ADDR_WIDTH and ROUTER_COUNT constants, also used by row_router_controller.
- One natural sub-module, stride_axis_counter, instantiated twice (x axis and y axis). It holds the origin and index registers. Inputs are clear/load, step amount, index step, k_size and i_size. It outputs a combinational "next step in range" flag.

Test Plan:
- i_size=5, k=3, stride=1, RC=4; controller model asserts done 3 cycles after enable -> items (0,0),(1,0),(2,0) issued; 3 o_rrc_clear pulses; o_done once.
- i_size=8, k=3, stride=1, RC=2 -> 18 items, o_y in {0,2,4}, o_x 0..5 per tile; o_busy high continuously until o_done.
- i_size=7, k=3, stride=2, RC=4 -> items (0,0),(1,0),(2,0) only. Checks stride path and the row exit at iy=8.
- k=6, i_size=5 start -> o_err high exactly 1 cycle, o_busy and o_rrc_en stay 0; stride=0 start -> same response.
- i_rrc_done held low 10 cycles during an item -> o_rrc_en stays 1 and coordinates stable; a spurious i_rrc_done in CLEAR is ignored.
- Mid-sequence i_reg_clear (and separately i_nrst) during ISSUE at item 2 -> all outputs 0 next cycle, no o_done. A subsequent start replays from (0,0).
